// File: rtl/l1_cache_types.sv
// Shared L1 cache interface types: line/address defaults, request/feedback structs
// and the L1-to-L2 arbiter state encoding.
package l1_cache_types;

    localparam int DEFAULT_LINE_BITS = 256;
    localparam int DEFAULT_ADDR_BITS = 32;

    // Fixed-width structs used by the existing 256-bit line instantiations.
    typedef struct packed {
        logic [DEFAULT_ADDR_BITS-1:0] addr;
        logic                         read;
        logic                         write;
        logic [DEFAULT_LINE_BITS-1:0] wdata;
    } l1_mem_req_t;

    typedef struct packed {
        logic                         resp;
        logic [DEFAULT_LINE_BITS-1:0] rdata;
    } l1_mem_fb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } l1_arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request scanning from ptr
// upward, wrapping modulo NUM_PORTS.
module rr_priority_pick #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_BITS  = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_BITS-1:0]  ptr,
    output logic                 valid,
    output logic [PTR_BITS-1:0]  idx
);

    int cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (int'(ptr) + k) % NUM_PORTS;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = PTR_BITS'(cand);
            end
        end
    end

endmodule

// File: rtl/l1_rr_arbiter.sv
// Round-robin arbiter from NUM_PORTS L1 requesters onto one L2 port; one line
// transaction at a time, winner's request latched and replayed until L2 responds.
//
//   state | meaning
//   IDLE  | waiting for any read/write request; grants and latches on the edge
//   BUSY  | latched op driven to L2 until l2_mem_resp, resp steered to winner
//   DONE  | one dead cycle so the winner can drop its request
module l1_rr_arbiter
    import l1_cache_types::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int LINE_BITS = DEFAULT_LINE_BITS,
    parameter int PTR_BITS  = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] l1_mem_addr,
    input  logic [NUM_PORTS-1:0]           l1_mem_read,
    input  logic [NUM_PORTS-1:0]           l1_mem_write,
    input  logic [NUM_PORTS*LINE_BITS-1:0] l1_mem_wdata,
    output logic [NUM_PORTS-1:0]           l1_mem_resp,
    output logic [LINE_BITS-1:0]           l1_mem_rdata,
    output logic [ADDR_BITS-1:0]           l2_mem_addr,
    output logic                           l2_mem_read,
    output logic                           l2_mem_write,
    output logic [LINE_BITS-1:0]           l2_mem_wdata,
    input  logic                           l2_mem_resp,
    input  logic [LINE_BITS-1:0]           l2_mem_rdata
);

    l1_arb_state_t         state_q, state_d;
    logic [PTR_BITS-1:0]   ptr_q;
    logic [PTR_BITS-1:0]   win_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [LINE_BITS-1:0]  wdata_q;
    logic                  read_q, write_q;

    logic [NUM_PORTS-1:0]  req;
    logic                  pick_valid;
    logic [PTR_BITS-1:0]   pick_idx;
    logic [ADDR_BITS-1:0]  sel_addr;
    logic [LINE_BITS-1:0]  sel_wdata;
    logic                  sel_read, sel_write;
    logic                  grant;

    assign req   = l1_mem_read | l1_mem_write;
    assign grant = (state_q == IDLE) && pick_valid;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_BITS  (PTR_BITS)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A port raising both read and write is issued as a write.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_idx == PTR_BITS'(i)) begin
                sel_addr  = l1_mem_addr[i*ADDR_BITS +: ADDR_BITS];
                sel_wdata = l1_mem_wdata[i*LINE_BITS +: LINE_BITS];
                sel_write = l1_mem_write[i];
                sel_read  = l1_mem_read[i] & ~l1_mem_write[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        l2_mem_read  = 1'b0;
        l2_mem_write = 1'b0;
        l1_mem_resp  = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) state_d = BUSY;
            end
            BUSY: begin
                l2_mem_read  = read_q;
                l2_mem_write = write_q;
                if (l2_mem_resp) begin
                    l1_mem_resp[win_q] = 1'b1;
                    state_d            = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign l2_mem_addr  = addr_q;
    assign l2_mem_wdata = wdata_q;
    assign l1_mem_rdata = l2_mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else if (grant) begin
            win_q   <= pick_idx;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            read_q  <= sel_read;
            write_q <= sel_write;
        end
    end

    // Next scan starts just past the port that was served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if ((state_q == BUSY) && l2_mem_resp) begin
            if (win_q == PTR_BITS'(NUM_PORTS - 1)) ptr_q <= '0;
            else                                   ptr_q <= win_q + PTR_BITS'(1);
        end
    end

endmodule

// File: tb/tb_l1_rr_arbiter.sv
// Directed plus randomized bench for l1_rr_arbiter (4 ports) against a
// round-robin reference model kept as a plain integer pointer.
module tb_l1_rr_arbiter;

    localparam int NP = 4;
    localparam int AB = 32;
    localparam int LB = 256;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NP*AB-1:0]     l1_mem_addr;
    logic [NP-1:0]        l1_mem_read;
    logic [NP-1:0]        l1_mem_write;
    logic [NP*LB-1:0]     l1_mem_wdata;
    logic [NP-1:0]        l1_mem_resp;
    logic [LB-1:0]        l1_mem_rdata;
    logic [AB-1:0]        l2_mem_addr;
    logic                 l2_mem_read;
    logic                 l2_mem_write;
    logic [LB-1:0]        l2_mem_wdata;
    logic                 l2_mem_resp;
    logic [LB-1:0]        l2_mem_rdata;

    int checks    = 0;
    int failures  = 0;
    int model_ptr = 0;
    int cyc       = 0;

    l1_rr_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_BITS (AB),
        .LINE_BITS (LB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .l1_mem_addr  (l1_mem_addr),
        .l1_mem_read  (l1_mem_read),
        .l1_mem_write (l1_mem_write),
        .l1_mem_wdata (l1_mem_wdata),
        .l1_mem_resp  (l1_mem_resp),
        .l1_mem_rdata (l1_mem_rdata),
        .l2_mem_addr  (l2_mem_addr),
        .l2_mem_read  (l2_mem_read),
        .l2_mem_write (l2_mem_write),
        .l2_mem_wdata (l2_mem_wdata),
        .l2_mem_resp  (l2_mem_resp),
        .l2_mem_rdata (l2_mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r;
        for (int i = 0; i < LB/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference arbitration: first requester at model_ptr, model_ptr+1, ... mod NP.
    function automatic int model_pick(input logic [NP-1:0] r);
        int w = -1;
        for (int k = 0; k < NP; k++) begin
            int j = (model_ptr + k) % NP;
            if (w < 0 && r[j]) w = j;
        end
        return w;
    endfunction

    // Called while the DUT is idle with requests already driven.
    task automatic run_txn(input int lat, input logic [LB-1:0] rd, input bit drop,
                           output int winner, output int t_grant);
        logic [AB-1:0] ea;
        logic [LB-1:0] ew;
        logic          er, ewr;
        int            hi;
        winner = model_pick(l1_mem_read | l1_mem_write);
        if (winner < 0) begin
            $display("FAIL run_txn called without requests");
            $fatal(1, "bench sequencing");
        end
        ea  = l1_mem_addr[winner*AB +: AB];
        ew  = l1_mem_wdata[winner*LB +: LB];
        ewr = l1_mem_write[winner];
        er  = l1_mem_read[winner] & ~l1_mem_write[winner];
        step();
        t_grant = cyc;
        if (drop) begin
            l1_mem_addr[winner*AB +: AB]  = ea ^ 32'h7F;
            l1_mem_wdata[winner*LB +: LB] = ~ew;
            l1_mem_read[winner]           = 1'b0;
            l1_mem_write[winner]          = 1'b0;
        end
        hi = 0;
        for (int c = 1; c <= lat; c++) begin
            if (c == lat) begin
                l2_mem_resp  = 1'b1;
                l2_mem_rdata = rd;
            end
            #1;
            chk("l2_addr", l2_mem_addr, ea);
            chk("l2_wdata", l2_mem_wdata, ew);
            chk("l2_read", l2_mem_read, er);
            chk("l2_write", l2_mem_write, ewr);
            chk("l1_resp", l1_mem_resp, (c == lat) ? (NP'(1) << winner) : NP'(0));
            if (c == lat) chk("l1_rdata", l1_mem_rdata, rd);
            if (l2_mem_read || l2_mem_write) hi++;
            step();
        end
        // DONE: any stray L2 resp must not reach an L1 port.
        l2_mem_resp = 1'($urandom % 2);
        #1;
        chk("done_read", l2_mem_read, 1'b0);
        chk("done_write", l2_mem_write, 1'b0);
        chk("done_resp", l1_mem_resp, NP'(0));
        chk("busy_cycles", hi, lat);
        step();
        l2_mem_resp = 1'b0;
        model_ptr = (winner + 1) % NP;
    endtask

    task automatic clear_req();
        l1_mem_read  = '0;
        l1_mem_write = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        #1;
    endtask

    initial begin
        int w, t, t_prev;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [LB-1:0] a5;
        a5 = {(LB/8){8'hA5}};

        rst          = 1'b1;
        l1_mem_addr  = '0;
        l1_mem_wdata = '0;
        l1_mem_read  = '0;
        l1_mem_write = '0;
        l2_mem_resp  = 1'b0;
        l2_mem_rdata = rand_line();
        step();
        step();
        chk("rst_l2_addr", l2_mem_addr, 0);
        chk("rst_l2_wdata", l2_mem_wdata, 0);
        chk("rst_l2_read", l2_mem_read, 1'b0);
        chk("rst_l2_write", l2_mem_write, 1'b0);
        chk("rst_l1_resp", l1_mem_resp, 0);
        chk("rst_rdata_pass", l1_mem_rdata, l2_mem_rdata);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single requester: port1 read, L2 answers in the 5th busy cycle.
        l1_mem_addr[1*AB +: AB] = 32'h0000_1040;
        l1_mem_read[1]          = 1'b1;
        run_txn(5, a5, 1'b1, w, t);
        chk("single_winner", w, 1);
        // Pointer now past port1: ports 0 and 1 requesting, scan 2,3,0 picks 0.
        l1_mem_read = 4'b0011;
        run_txn(2, rand_line(), 1'b1, w, t);
        chk("ptr_after_single", w, 0);
        clear_req();
        step();

        // Rotation: all four ports requesting continuously, 1-cycle L2.
        pulse_reset();
        for (int i = 0; i < NP; i++) l1_mem_addr[i*AB +: AB] = $urandom;
        l1_mem_read = '1;
        t_prev = 0;
        for (int n = 0; n < 5; n++) begin
            run_txn(1, rand_line(), 1'b0, w, t);
            chk("rotation_order", w, exp_order[n]);
            if (n > 0) chk("rotation_spacing", t - t_prev, 3);
            t_prev = t;
        end
        clear_req();
        step();

        // Latched op survives addr change and write drop by the winner.
        pulse_reset();
        l1_mem_addr[0 +: AB]  = 32'h80;
        l1_mem_wdata[0 +: LB] = LB'(32'h1234);
        l1_mem_write[0]       = 1'b1;
        run_txn(3, rand_line(), 1'b1, w, t);
        chk("latch_winner", w, 0);
        clear_req();

        // Read and write together on port2 issue as a write.
        l1_mem_read[2]  = 1'b1;
        l1_mem_write[2] = 1'b1;
        l1_mem_addr[2*AB +: AB] = 32'h0000_2200;
        run_txn(2, rand_line(), 1'b1, w, t);
        chk("rw_winner", w, 2);

        // Reset between edges while BUSY; pointer (3) would favour port3 without it.
        l1_mem_read = 4'b1010;
        step();
        #2;
        chk("pre_rst_busy", l2_mem_read, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_read", l2_mem_read, 1'b0);
        chk("async_rst_addr", l2_mem_addr, 0);
        chk("async_rst_resp", l1_mem_resp, 0);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        #1;
        run_txn(2, rand_line(), 1'b0, w, t);
        chk("post_rst_winner", w, 1);
        clear_req();
        step();

        // Spurious L2 resp while IDLE.
        step();
        l2_mem_resp = 1'b1;
        #1;
        chk("spurious_resp", l1_mem_resp, 0);
        step();
        l2_mem_resp = 1'b0;
        #1;
        chk("spurious_read", l2_mem_read, 1'b0);
        chk("spurious_write", l2_mem_write, 1'b0);
        l1_mem_read[3] = 1'b1;
        run_txn(2, rand_line(), 1'b1, w, t);
        chk("spurious_then_grant", w, 3);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [NP-1:0] rq, wq;
            rq = NP'($urandom);
            wq = NP'($urandom) & NP'($urandom);
            if ((rq | wq) == '0) rq[$urandom_range(NP-1, 0)] = 1'b1;
            for (int i = 0; i < NP; i++) begin
                l1_mem_addr[i*AB +: AB]  = $urandom;
                l1_mem_wdata[i*LB +: LB] = rand_line();
            end
            l1_mem_read  = rq;
            l1_mem_write = wq;
            run_txn(int'($urandom_range(4, 1)), rand_line(), 1'($urandom % 2), w, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_rr_arbiter.md
# l1_rr_arbiter

Parametrised N-port round-robin arbiter between the L1 caches (icache, dcache, prefetcher, …) and the single L2 port. One L1 line transaction runs at a time; the winner's request is latched and replayed to L2 until `mem_resp`. The response is steered back to the winner only. Successor to the fixed two-port arbiter, generalised in port count, line width and address width, with fair rotation replacing fixed priority.

## Interface
Parameters:
- NUM_PORTS, 2, number of L1 requesters (≥2)
- ADDR_BITS, 32, address width
- LINE_BITS, 256, cache-line width
- PTR_BITS, $clog2(NUM_PORTS), derived, not overridden

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- l1_mem_addr  in  NUM_PORTS*ADDR_BITS  per-port line address, port i at [i*ADDR_BITS +: ADDR_BITS]
- l1_mem_read  in  NUM_PORTS  per-port read request
- l1_mem_write  in  NUM_PORTS  per-port write request
- l1_mem_wdata  in  NUM_PORTS*LINE_BITS  per-port write line
- l1_mem_resp  out  NUM_PORTS  per-port completion pulse
- l1_mem_rdata  out  LINE_BITS  read line, shared; valid only with a resp bit
- l2_mem_addr  out  ADDR_BITS  latched winner address
- l2_mem_read  out  1  read to L2
- l2_mem_write  out  1  write to L2
- l2_mem_wdata  out  LINE_BITS  latched winner write line
- l2_mem_resp  in  1  L2 completion
- l2_mem_rdata  in  LINE_BITS  L2 read line

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: a port requests when read|write. If any, pick first requester scanning ptr, ptr+1, … mod NUM_PORTS. Capture winner index, addr, wdata, and op into registers. Go to BUSY. No requests: stay in IDLE.
- Read and write both high on one port is treated as write: latched read=0, write=1.
- BUSY: l2_mem_read/write driven from the latched op, addr/wdata from the latched copy. Later changes or drops on the winner's inputs are ignored.
- On l2_mem_resp=1: l1_mem_resp[winner]=1 combinationally, l1_mem_rdata=l2_mem_rdata in that cycle. Go to DONE. ptr ← (winner+1) mod NUM_PORTS, wrapping at NUM_PORTS-1 → 0.
- DONE: one dead cycle; L2 outputs low, no resp. Lets the requester drop its request before re-arbitration. Then go to IDLE.
- Non-winners never see resp. Their pending requests wait.
- Fairness bound: a continuously requesting port is granted within NUM_PORTS transactions.
- l1_mem_rdata is l2_mem_rdata passed through at all times. It is meaningful only with a resp bit.
- Reset (any time, including mid-BUSY), asynchronous:
  - state → IDLE, ptr → 0, latched registers → 0
  - l2_mem_read/write → 0, all l1_mem_resp → 0
  - An L2 transaction in flight is abandoned. L2 is required to be reset in the same reset domain.

## Timing
- Request high at edge k (state IDLE) → l2_mem_read/write high from after edge k (cycle k+1).
- L2 resp in cycle m → L1 resp in cycle m (zero-cycle pass-through), state DONE at m+1, IDLE at m+2.
- Earliest next grant is at edge m+2. Back-to-back transactions have a 2-cycle bubble.
- Outputs after reset:
  - l2_mem_addr=0, l2_mem_wdata=0, l2_mem_read=0, l2_mem_write=0
  - l1_mem_resp=0, l1_mem_rdata=l2_mem_rdata
- l2_mem_resp while IDLE or DONE is ignored (protocol error), with no state change.

## Structure
- Extend package l1_cache_types:
  - enum l1_arb_state_t {IDLE, BUSY, DONE}
  - DEFAULT_LINE_BITS=256, DEFAULT_ADDR_BITS=32
  - Existing request/feedback structs remain for the 256-bit instantiations.
- One sub-module: rr_priority_pick, combinational. Inputs req[NUM_PORTS], ptr. Outputs valid, idx.
- Top holds the FSM, ptr, latches and response steering.

## Test plan
- Single requester, NUM_PORTS=2: port1 read addr 0x0000_1040, L2 resp after 5 cycles with rdata 0xA5…A5 → l2_mem_read high 5 cycles, l1_mem_resp=2'b10 for 1 cycle, rdata matches; ptr=0 after.
- Rotation, NUM_PORTS=4, all ports requesting continuously, L2 resp after 1 cycle → grant order 0,1,2,3,0. Each resp one cycle. Transactions start every 3 cycles.
- Latch check: port0 write addr 0x80, wdata 0x1234, then change addr to 0xFF and drop write in BUSY → L2 sees addr 0x80, write held until resp.
- Read+write both high on port2 → L2 sees write only.
- Reset asserted mid-BUSY, asynchronously between edges → l2_mem_read drops immediately. After release, first grant goes to lowest requesting port (ptr=0).
- Spurious l2_mem_resp in IDLE → no l1_mem_resp, state stays IDLE.
